// File: rtl/rs_pkg.sv
// rs_pkg: shared types and constants for the reservation station
package rs_pkg;
    localparam int NUM_RS = 4;
    localparam int OVR_TAG_LO = 0;
    localparam int OVR_SLOT_LO = 3;
    localparam int OVR_RS2 = 5;
    typedef logic [2:0] tag_t;
    typedef logic [1:0] slot_t;
    typedef enum logic [1:0] {FREE, WAIT, READY, ISSUED} rs_state_e;
endpackage

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot with operand capture and CDB wakeup
module rs_entry
    import rs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter tag_t TAG = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic              s1_rdy,
    input  tag_t              s1_tag,
    input  logic [DATA_W-1:0] s1_val,
    input  logic              s2_rdy,
    input  tag_t              s2_tag,
    input  logic [DATA_W-1:0] s2_val,
    input  logic              ovr_hit,
    input  logic              ovr_rs2,
    input  tag_t              ovr_tag,
    input  logic              cdb_valid,
    input  tag_t              cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              accept,
    output rs_state_e         state,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b
);
    logic r1, r2, live, o1, o2, p1, p2, w1, w2, n_r1, n_r2, rel;
    tag_t t1, t2, p_t1, p_t2;
    logic [DATA_W-1:0] n_a, n_b;
    rs_state_e n_state;
    // overwrite is layered on allocation, then the CDB bypasses into the result
    always_comb begin
        live = alloc || state == WAIT || state == READY;
        o1 = live && ovr_hit && !ovr_rs2;
        o2 = live && ovr_hit && ovr_rs2;
        p1 = o1 ? 1'b0 : alloc ? s1_rdy : r1;
        p2 = o2 ? 1'b0 : alloc ? s2_rdy : r2;
        p_t1 = o1 ? ovr_tag : alloc ? s1_tag : t1;
        p_t2 = o2 ? ovr_tag : alloc ? s2_tag : t2;
        w1 = live && cdb_valid && !p1 && p_t1 == cdb_tag;
        w2 = live && cdb_valid && !p2 && p_t2 == cdb_tag;
        n_r1 = p1 || w1;
        n_r2 = p2 || w2;
        n_a = w1 ? cdb_data : alloc ? s1_val : a;
        n_b = w2 ? cdb_data : alloc ? s2_val : b;
        rel = cdb_valid && cdb_tag == TAG && state == ISSUED;
        n_state = rel ? FREE : accept ? ISSUED : live ? (n_r1 && n_r2 ? READY : WAIT) : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
            r1 <= 1'b0;
            r2 <= 1'b0;
            t1 <= '0;
            t2 <= '0;
            a <= '0;
            b <= '0;
        end else begin
            state <= n_state;
            r1 <= n_r1;
            r2 <= n_r2;
            t1 <= p_t1;
            t2 <= p_t2;
            a <= n_a;
            b <= n_b;
        end
    end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: four-slot station with dual allocation, CDB wakeup and locked issue
module reservation_station
    import rs_pkg::*;
#(
    parameter logic UNIT_ID = 1'b0,
    parameter int   DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d0_valid,
    input  logic [1:0]        d0_slot,
    input  logic              d0_src1_rdy,
    input  logic [2:0]        d0_src1_tag,
    input  logic [DATA_W-1:0] d0_src1_val,
    input  logic              d0_src2_rdy,
    input  logic [2:0]        d0_src2_tag,
    input  logic [DATA_W-1:0] d0_src2_val,
    input  logic              d1_valid,
    input  logic [1:0]        d1_slot,
    input  logic              d1_src1_rdy,
    input  logic [2:0]        d1_src1_tag,
    input  logic [DATA_W-1:0] d1_src1_val,
    input  logic              d1_src2_rdy,
    input  logic [2:0]        d1_src2_tag,
    input  logic [DATA_W-1:0] d1_src2_val,
    input  logic              ovr_valid,
    input  logic [5:0]        ovr,
    input  logic              cdb_valid,
    input  logic [2:0]        cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [2:0]        issue_tag,
    output logic [DATA_W-1:0] issue_a,
    output logic [DATA_W-1:0] issue_b,
    output logic [3:0]        rs_busy,
    output logic [2:0]        count_free,
    output logic              alloc_err
);
    rs_state_e st [NUM_RS];
    logic [DATA_W-1:0] ea [NUM_RS];
    logic [DATA_W-1:0] eb [NUM_RS];
    logic a0, a1, err, keep, lock_v;
    slot_t low, sel, lock_idx;
    // d0 has priority; d1 loses any slot d0 also names, even if d0 itself fails
    always_comb begin
        a0 = d0_valid && st[d0_slot] == FREE;
        a1 = d1_valid && st[d1_slot] == FREE && !(d0_valid && d0_slot == d1_slot);
        err = (d0_valid && !a0) || (d1_valid && !a1);
    end
    for (genvar i = 0; i < NUM_RS; i++) begin : g_ent
        logic u0, al;
        assign u0 = a0 && d0_slot == slot_t'(i);
        assign al = u0 || (a1 && d1_slot == slot_t'(i));
        rs_entry #(.DATA_W(DATA_W), .TAG({UNIT_ID, slot_t'(i)})) u_ent (
            .clk(clk),
            .rst(rst),
            .alloc(al),
            .s1_rdy(u0 ? d0_src1_rdy : d1_src1_rdy),
            .s1_tag(u0 ? d0_src1_tag : d1_src1_tag),
            .s1_val(u0 ? d0_src1_val : d1_src1_val),
            .s2_rdy(u0 ? d0_src2_rdy : d1_src2_rdy),
            .s2_tag(u0 ? d0_src2_tag : d1_src2_tag),
            .s2_val(u0 ? d0_src2_val : d1_src2_val),
            .ovr_hit(ovr_valid && ovr[OVR_SLOT_LO +: 2] == slot_t'(i)),
            .ovr_rs2(ovr[OVR_RS2]),
            .ovr_tag(ovr[OVR_TAG_LO +: 3]),
            .cdb_valid(cdb_valid),
            .cdb_tag(cdb_tag),
            .cdb_data(cdb_data),
            .accept(issue_valid && issue_ready && sel == slot_t'(i)),
            .state(st[i]),
            .a(ea[i]),
            .b(eb[i])
        );
        assign rs_busy[i] = st[i] != FREE;
    end
    // a latched offer sticks while its entry stays READY, else lowest READY wins
    always_comb begin
        issue_valid = 1'b0;
        low = '0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            if (st[k] == READY) begin
                issue_valid = 1'b1;
                low = slot_t'(k);
            end
        end
        keep = lock_v && st[lock_idx] == READY;
        sel = keep ? lock_idx : low;
        issue_tag = issue_valid ? {UNIT_ID, sel} : '0;
        issue_a = issue_valid ? ea[sel] : '0;
        issue_b = issue_valid ? eb[sel] : '0;
    end
    always_comb begin
        count_free = '0;
        for (int k = 0; k < NUM_RS; k++) count_free = count_free + 3'(!rs_busy[k]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_v <= 1'b0;
            lock_idx <= '0;
            alloc_err <= 1'b0;
        end else begin
            lock_v <= issue_valid && !issue_ready;
            lock_idx <= sel;
            alloc_err <= err;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenario tests for the reservation station
module tb_reservation_station;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d0_valid = 0, d1_valid = 0;
    logic [1:0] d0_slot = 0, d1_slot = 0;
    logic d0_src1_rdy = 0, d0_src2_rdy = 0, d1_src1_rdy = 0, d1_src2_rdy = 0;
    logic [2:0] d0_src1_tag = 0, d0_src2_tag = 0, d1_src1_tag = 0, d1_src2_tag = 0;
    logic [31:0] d0_src1_val = 0, d0_src2_val = 0, d1_src1_val = 0, d1_src2_val = 0;
    logic ovr_valid = 0;
    logic [5:0] ovr = 0;
    logic cdb_valid = 0;
    logic [2:0] cdb_tag = 0;
    logic [31:0] cdb_data = 0;
    logic issue_valid, issue_ready = 0;
    logic [2:0] issue_tag;
    logic [31:0] issue_a, issue_b;
    logic [3:0] rs_busy;
    logic [2:0] count_free;
    logic alloc_err;
    int checks = 0;
    int errors = 0;

    reservation_station #(.UNIT_ID(1'b0), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .d0_valid(d0_valid), .d0_slot(d0_slot),
        .d0_src1_rdy(d0_src1_rdy), .d0_src1_tag(d0_src1_tag), .d0_src1_val(d0_src1_val),
        .d0_src2_rdy(d0_src2_rdy), .d0_src2_tag(d0_src2_tag), .d0_src2_val(d0_src2_val),
        .d1_valid(d1_valid), .d1_slot(d1_slot),
        .d1_src1_rdy(d1_src1_rdy), .d1_src1_tag(d1_src1_tag), .d1_src1_val(d1_src1_val),
        .d1_src2_rdy(d1_src2_rdy), .d1_src2_tag(d1_src2_tag), .d1_src2_val(d1_src2_val),
        .ovr_valid(ovr_valid), .ovr(ovr),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_a(issue_a), .issue_b(issue_b),
        .rs_busy(rs_busy), .count_free(count_free), .alloc_err(alloc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d0_valid = 0;
        d1_valid = 0;
        ovr_valid = 0;
        cdb_valid = 0;
    endtask

    task automatic set_d0(input logic [1:0] s, input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [2:0] t2, input logic [31:0] v2);
        d0_valid = 1; d0_slot = s;
        d0_src1_rdy = r1; d0_src1_tag = t1; d0_src1_val = v1;
        d0_src2_rdy = r2; d0_src2_tag = t2; d0_src2_val = v2;
    endtask

    task automatic set_d1(input logic [1:0] s, input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [2:0] t2, input logic [31:0] v2);
        d1_valid = 1; d1_slot = s;
        d1_src1_rdy = r1; d1_src1_tag = t1; d1_src1_val = v1;
        d1_src2_rdy = r2; d1_src2_tag = t2; d1_src2_val = v2;
    endtask

    task automatic set_cdb(input logic [2:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        issue_ready = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rs_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b exp 0000", rs_busy); end
        checks++; if (count_free !== 3'd4) begin errors++; $display("FAIL reset_count: got %0d exp 4", count_free); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", issue_valid); end
        checks++; if (issue_tag !== 3'd0) begin errors++; $display("FAIL reset_tag: got %b exp 000", issue_tag); end
        checks++; if (issue_a !== 32'd0 || issue_b !== 32'd0) begin errors++; $display("FAIL reset_payload: got %h/%h exp 0/0", issue_a, issue_b); end
        checks++; if (alloc_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", alloc_err); end
    endtask

    task automatic test_alloc_issue();
        do_reset();
        set_d0(0, 1, 0, 5, 1, 0, 7);
        tick();
        clear_inputs();
        checks++; if (rs_busy !== 4'b0001) begin errors++; $display("FAIL alloc_busy: got %b exp 0001", rs_busy); end
        checks++; if (count_free !== 3'd3) begin errors++; $display("FAIL alloc_count: got %0d exp 3", count_free); end
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 3'b000) begin errors++; $display("FAIL alloc_issue: got v=%b tag=%b exp v=1 tag=000", issue_valid, issue_tag); end
        checks++; if (issue_a !== 32'd5 || issue_b !== 32'd7) begin errors++; $display("FAIL alloc_payload: got %0d/%0d exp 5/7", issue_a, issue_b); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        checks++; if (issue_valid !== 1'b0 || rs_busy !== 4'b0001) begin errors++; $display("FAIL issued_state: got v=%b busy=%b exp v=0 busy=0001", issue_valid, rs_busy); end
        set_cdb(3'b000, 32'h99);
        tick();
        clear_inputs();
        checks++; if (rs_busy !== 4'b0000 || count_free !== 3'd4) begin errors++; $display("FAIL release: got busy=%b cnt=%0d exp 0000/4", rs_busy, count_free); end
    endtask

    task automatic test_conflict();
        do_reset();
        set_d0(2, 1, 0, 1, 1, 0, 2);
        set_d1(2, 1, 0, 3, 1, 0, 4);
        tick();
        clear_inputs();
        checks++; if (alloc_err !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b exp 1", alloc_err); end
        checks++; if (count_free !== 3'd3 || rs_busy !== 4'b0100) begin errors++; $display("FAIL conflict_busy: got busy=%b cnt=%0d exp 0100/3", rs_busy, count_free); end
        checks++; if (issue_tag !== 3'b010 || issue_a !== 32'd1 || issue_b !== 32'd2) begin errors++; $display("FAIL conflict_winner: got tag=%b a=%0d b=%0d exp 010/1/2", issue_tag, issue_a, issue_b); end
        tick();
        checks++; if (alloc_err !== 1'b0) begin errors++; $display("FAIL conflict_pulse: got %b exp 0", alloc_err); end
    endtask

    task automatic test_wakeup();
        do_reset();
        set_d0(1, 1, 0, 3, 0, 3'b101, 0);
        tick();
        clear_inputs();
        checks++; if (issue_valid !== 1'b0 || rs_busy !== 4'b0010) begin errors++; $display("FAIL wait_state: got v=%b busy=%b exp 0/0010", issue_valid, rs_busy); end
        set_cdb(3'b101, 32'h2A);
        tick();
        clear_inputs();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 3'b001) begin errors++; $display("FAIL wakeup_issue: got v=%b tag=%b exp 1/001", issue_valid, issue_tag); end
        checks++; if (issue_a !== 32'd3 || issue_b !== 32'h2A) begin errors++; $display("FAIL wakeup_payload: got %h/%h exp 3/2a", issue_a, issue_b); end
        do_reset();
        set_d0(1, 1, 0, 3, 0, 3'b101, 0);
        set_cdb(3'b101, 32'h2A);
        tick();
        clear_inputs();
        checks++; if (issue_valid !== 1'b1 || issue_b !== 32'h2A) begin errors++; $display("FAIL bypass: got v=%b b=%h exp 1/2a", issue_valid, issue_b); end
    endtask

    task automatic test_overwrite();
        do_reset();
        set_d0(1, 1, 0, 8, 1, 0, 9);
        tick();
        clear_inputs();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL ovr_pre: got %b exp 1", issue_valid); end
        ovr_valid = 1; ovr = {1'b1, 2'b01, 3'b110};
        tick();
        clear_inputs();
        checks++; if (issue_valid !== 1'b0 || rs_busy !== 4'b0010) begin errors++; $display("FAIL ovr_drop: got v=%b busy=%b exp 0/0010", issue_valid, rs_busy); end
        ovr_valid = 1; ovr = {1'b0, 2'b11, 3'b010};
        tick();
        clear_inputs();
        checks++; if (rs_busy !== 4'b0010) begin errors++; $display("FAIL ovr_free_ignored: got %b exp 0010", rs_busy); end
        set_cdb(3'b110, 32'h55);
        tick();
        clear_inputs();
        checks++; if (issue_valid !== 1'b1 || issue_a !== 32'd8 || issue_b !== 32'h55) begin errors++; $display("FAIL ovr_restore: got v=%b a=%h b=%h exp 1/8/55", issue_valid, issue_a, issue_b); end
    endtask

    task automatic test_lock();
        do_reset();
        set_d0(3, 1, 0, 32'h33, 1, 0, 32'h44);
        tick();
        clear_inputs();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 3'b011) begin errors++; $display("FAIL lock_first: got v=%b tag=%b exp 1/011", issue_valid, issue_tag); end
        set_d0(0, 1, 0, 32'h11, 1, 0, 32'h22);
        tick();
        clear_inputs();
        checks++; if (issue_tag !== 3'b011 || issue_a !== 32'h33) begin errors++; $display("FAIL lock_hold: got tag=%b a=%h exp 011/33", issue_tag, issue_a); end
        tick();
        checks++; if (issue_tag !== 3'b011 || issue_b !== 32'h44) begin errors++; $display("FAIL lock_hold2: got tag=%b b=%h exp 011/44", issue_tag, issue_b); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 3'b000 || issue_a !== 32'h11) begin errors++; $display("FAIL lock_next: got v=%b tag=%b a=%h exp 1/000/11", issue_valid, issue_tag, issue_a); end
        checks++; if (rs_busy !== 4'b1001) begin errors++; $display("FAIL lock_busy: got %b exp 1001", rs_busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_d0(0, 1, 0, 1, 1, 0, 10);
        set_d1(1, 1, 0, 2, 1, 0, 20);
        tick();
        clear_inputs();
        checks++; if (rs_busy !== 4'b0011 || count_free !== 3'd2) begin errors++; $display("FAIL b2b_busy: got busy=%b cnt=%0d exp 0011/2", rs_busy, count_free); end
        checks++; if (issue_tag !== 3'b000) begin errors++; $display("FAIL b2b_first: got %b exp 000", issue_tag); end
        issue_ready = 1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 3'b001 || issue_a !== 32'd2) begin errors++; $display("FAIL b2b_second: got v=%b tag=%b a=%0d exp 1/001/2", issue_valid, issue_tag, issue_a); end
        tick();
        issue_ready = 0;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b exp 0", issue_valid); end
    endtask

    task automatic test_full_release();
        do_reset();
        set_d0(0, 1, 0, 1, 1, 0, 2);
        set_d1(1, 1, 0, 3, 1, 0, 4);
        tick();
        set_d0(2, 0, 3'b111, 0, 1, 0, 0);
        set_d1(3, 0, 3'b111, 0, 1, 0, 0);
        tick();
        clear_inputs();
        checks++; if (rs_busy !== 4'b1111 || count_free !== 3'd0) begin errors++; $display("FAIL full: got busy=%b cnt=%0d exp 1111/0", rs_busy, count_free); end
        set_d0(1, 1, 0, 5, 1, 0, 5);
        tick();
        clear_inputs();
        checks++; if (alloc_err !== 1'b1 || count_free !== 3'd0) begin errors++; $display("FAIL full_reject: got err=%b cnt=%0d exp 1/0", alloc_err, count_free); end
        set_cdb(3'b001, 32'h0);
        tick();
        clear_inputs();
        checks++; if (alloc_err !== 1'b0 || rs_busy !== 4'b1111) begin errors++; $display("FAIL cdb_not_issued: got err=%b busy=%b exp 0/1111", alloc_err, rs_busy); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        checks++; if (issue_tag !== 3'b001) begin errors++; $display("FAIL full_next_offer: got %b exp 001", issue_tag); end
        set_cdb(3'b000, 32'h0);
        set_d0(0, 1, 0, 9, 1, 0, 9);
        tick();
        clear_inputs();
        checks++; if (alloc_err !== 1'b1 || rs_busy !== 4'b1110 || count_free !== 3'd1) begin errors++; $display("FAIL free_same_cycle: got err=%b busy=%b cnt=%0d exp 1/1110/1", alloc_err, rs_busy, count_free); end
        set_d0(0, 1, 0, 9, 1, 0, 9);
        tick();
        clear_inputs();
        checks++; if (alloc_err !== 1'b0 || rs_busy !== 4'b1111 || count_free !== 3'd0) begin errors++; $display("FAIL realloc: got err=%b busy=%b cnt=%0d exp 0/1111/0", alloc_err, rs_busy, count_free); end
    endtask

    task automatic test_rst_mid();
        rst = 1;
        tick();
        rst = 0;
        checks++; if (rs_busy !== 4'b0000 || count_free !== 3'd4) begin errors++; $display("FAIL mid_reset_busy: got busy=%b cnt=%0d exp 0000/4", rs_busy, count_free); end
        checks++; if (issue_valid !== 1'b0 || issue_tag !== 3'd0 || alloc_err !== 1'b0) begin errors++; $display("FAIL mid_reset_issue: got v=%b tag=%b err=%b exp 0/000/0", issue_valid, issue_tag, alloc_err); end
        set_d0(2, 1, 0, 32'h77, 1, 0, 32'h78);
        tick();
        clear_inputs();
        checks++; if (issue_tag !== 3'b010 || issue_a !== 32'h77) begin errors++; $display("FAIL mid_reset_after: got tag=%b a=%h exp 010/77", issue_tag, issue_a); end
    endtask

    initial begin
        test_reset();
        test_alloc_issue();
        test_conflict();
        test_wakeup();
        test_overwrite();
        test_lock();
        test_back_to_back();
        test_full_release();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
# reservation_station

Four-entry reservation station for the adder or multiplier functional unit. It accepts up to two same-cycle allocations from the two dispatch units and applies dispatch RAW overwrite commands. It captures operands from the common data bus (CDB) and issues ready entries to its functional unit. It reports slot occupancy (`rs_busy`, `count_free`) back to the dispatch units, which use it to pick slots.

## Interface
Parameters:
- UNIT_ID, 1'b0: tag MSB for this station (0 adder, 1 multiplier); tag of slot i = {UNIT_ID, i[1:0]}
- DATA_W, 32: operand width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- d0_valid, d1_valid  in  1 each  allocation request from dispatch unit 1 (priority) / 2
- d0_slot, d1_slot  in  2 each  target slot index
- d0_src1_rdy, d0_src2_rdy, d1_src1_rdy, d1_src2_rdy  in  1 each  operand value present
- d0_src1_tag … d1_src2_tag  in  3 each  producer tag when not ready
- d0_src1_val … d1_src2_val  in  DATA_W each  operand value when ready
- ovr_valid  in  1  RAW overwrite command strobe
- ovr  in  6  {is_rs2, slot[1:0], producer_tag[2:0]}
- cdb_valid  in  1  result broadcast strobe
- cdb_tag  in  3  producing tag
- cdb_data  in  DATA_W  result value
- issue_valid  out  1  an entry is offered to the FU
- issue_ready  in  1  FU accepts the offer
- issue_tag  out  3  tag of offered entry
- issue_a, issue_b  out  DATA_W each  operand values
- rs_busy  out  4  bit i = slot i not FREE
- count_free  out  3  number of FREE slots, 0..4
- alloc_err  out  1  one-cycle pulse: rejected allocation

## Operation
- Per-entry state: FREE → WAIT (an operand pending) → READY (both captured) → ISSUED → FREE.
- Allocation on port p succeeds if dp_valid and the slot is FREE in registered state. An allocation with both operands ready enters READY directly; otherwise it enters WAIT.
- Allocation to a non-FREE slot is dropped and pulses alloc_err.
- d0 and d1 targeting the same slot: d0 wins, d1 is dropped, alloc_err pulses.
- Overwrite on a FREE or ISSUED slot is ignored.
- Overwrite on a WAIT or READY slot marks operand (is_rs2 ? src2 : src1) not-ready with the given tag. A READY entry returns to WAIT.
- Overwrite in the same cycle as allocation of that slot is applied on top of the allocation.
- Wakeup: every not-ready operand whose tag equals cdb_tag under cdb_valid captures cdb_data. This includes operands being written the same cycle by allocation or overwrite (bypass).
- Release: cdb_valid with cdb_tag == {UNIT_ID, i} and entry i ISSUED moves entry i to FREE. CDB for a non-ISSUED own tag is ignored.
- Issue select: lowest-index READY entry. Once issue_valid rises, the selected index is latched and held with stable payload until issue_valid && issue_ready. Then the entry goes to ISSUED.
- count_free = popcount(~rs_busy), 3-bit, never wraps.

## Timing
- Reset values: all entries FREE, rs_busy=4'b0000, count_free=3'd4, issue_valid=0, issue_tag=0, issue_a=issue_b=0, alloc_err=0, issue lock cleared.
- Reset mid-operation discards all entries and any pending offer on the next edge.
- Allocation at edge N: rs_busy/count_free reflect it after edge N.
- Earliest issue_valid is the cycle after edge N, for an allocation with both operands ready (1-cycle latency). A CDB-woken entry issues the cycle after its capture edge.
- issue_valid and payload are functions of registered state only; no combinational path from dispatch/CDB inputs.
- Accept at edge M: the next READY entry may be offered from cycle M+1 (back-to-back issue).
- A slot freed by CDB at edge K is allocatable from edge K+1. Allocation in the same cycle as the freeing CDB is rejected.
- alloc_err asserts for exactly the cycle after the offending edge.

## Structure
- Shared package rs_pkg: tag_t (3-bit), slot_t (2-bit), rs_state_e {FREE, WAIT, READY, ISSUED}, NUM_RS = 4, overwrite field offsets.
- Sub-module rs_entry, instantiated ×4: one slot's state machine, operand registers and wakeup compare. Allocation arbitration, issue select/lock and counters live in the top.

## Test plan
- Reset, then d0 allocates slot 0 with operands 5 and 7 both ready (UNIT_ID=0) → rs_busy=0001, count_free=3; next cycle issue_valid=1, issue_tag=3'b000, a=5, b=7.
- d0 and d1 both target slot 2 → d0 entry stored, alloc_err pulses once, count_free drops by 1.
- Allocate slot 1 with src2 waiting on tag 3'b101; CDB tag 101, data 0x2A → issue next cycle with b=0x2A. Repeat with the CDB in the allocation cycle → same result (bypass).
- Overwrite {1,2'b01,3'b110} on a READY slot 1 → issue_valid drops for it; CDB tag 110 restores READY and operand b.
- Hold issue_ready=0 with slot 3 offered, then make slot 0 READY → offer stays on tag 011 until accepted; slot 0 is offered next.
- Fill all 4 slots → count_free=0; fifth allocation → alloc_err. CDB own tag of an ISSUED slot → that slot frees, count_free=1. Assert rst mid-run → reset values on the next cycle.
